// File: rtl/sequenciador_porta.sv
// Door sequencer: drives the LED-bar animation stage's door command and uses its
// fully-open/fully-closed indicators to step through open, dwell, close and fault states.
module sequenciador_porta #(
   parameter int DWELL_CICLOS   = 8,
   parameter int TIMEOUT_CICLOS = 12,
   parameter int CW             = 4
) (
   input  logic       clock_in,
   input  logic       reset_n,
   input  logic       chegou,
   input  logic       botao_abrir,
   input  logic       obstaculo,
   input  logic       port_a,
   input  logic       port_f,
   output logic       control_port,
   output logic       liberado,
   output logic       falha,
   output logic [2:0] estado
);

   typedef enum logic [2:0] {
      FECHADA  = 3'd0,
      ABRINDO  = 3'd1,
      ABERTA   = 3'd2,
      FECHANDO = 3'd3,
      FALHA    = 3'd4
   } estado_t;

   localparam logic [CW-1:0] DWELL_C  = CW'(DWELL_CICLOS);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CICLOS - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   estado_t       state_q, state_d;
   logic [CW-1:0] dwell_q, dwell_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic          control_q, control_d;
   logic          falha_q, falha_d;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v == CNT_MAX) sat_inc = v;
      else              sat_inc = v + CNT_ONE;
   endfunction

   function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
      if (v == CNT_ZERO) sat_dec = v;
      else               sat_dec = v - CNT_ONE;
   endfunction

   // Next-state, counter and registered-output decode
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      tmo_d   = tmo_q;
      case (state_q)
         FECHADA: begin
            if (chegou || botao_abrir) begin
               state_d = ABRINDO;
               tmo_d   = CNT_ZERO;
            end else begin
               state_d = FECHADA;
            end
         end
         ABRINDO: begin
            tmo_d = sat_inc(tmo_q);
            if (port_a && port_f) begin
               state_d = FALHA;
            end else if (port_a) begin
               state_d = ABERTA;
               dwell_d = DWELL_C;
            end else if (tmo_q == TMO_LAST) begin
               state_d = FALHA;
            end else begin
               state_d = ABRINDO;
            end
         end
         ABERTA: begin
            if (botao_abrir || obstaculo) begin
               dwell_d = DWELL_C;
            end else if (dwell_q == CNT_ZERO) begin
               state_d = FECHANDO;
               tmo_d   = CNT_ZERO;
            end else begin
               dwell_d = sat_dec(dwell_q);
            end
         end
         FECHANDO: begin
            tmo_d = sat_inc(tmo_q);
            // Inconsistent feedback is a fault even if a reopen is requested
            if (port_a && port_f) begin
               state_d = FALHA;
            end else if (obstaculo || botao_abrir) begin
               state_d = ABRINDO;
               tmo_d   = CNT_ZERO;
            end else if (port_f) begin
               state_d = FECHADA;
            end else if (tmo_q == TMO_LAST) begin
               state_d = FALHA;
            end else begin
               state_d = FECHANDO;
            end
         end
         FALHA: begin
            state_d = FALHA;
         end
         default: begin
            state_d = FECHADA;
         end
      endcase
      control_d = (state_d == FECHADA) || (state_d == FECHANDO);
      falha_d   = (state_d == FALHA);
   end

   // State, counters and output registers
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= FECHADA;
         dwell_q   <= CNT_ZERO;
         tmo_q     <= CNT_ZERO;
         control_q <= 1'b1;
         falha_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         tmo_q     <= tmo_d;
         control_q <= control_d;
         falha_q   <= falha_d;
      end
   end

   assign control_port = control_q;
   assign falha        = falha_q;
   assign estado       = state_q;
   assign liberado     = (state_q == FECHADA) && port_f;

endmodule

// File: tb/tb_sequenciador_porta.sv
// Scoreboard bench for sequenciador_porta: directed stimulus queues expected outputs,
// a monitor pops and compares them on the falling clock edge.
module tb_sequenciador_porta;

   logic       clock_in = 1'b0;
   logic       reset_n;
   logic       chegou, botao_abrir, obstaculo, port_a, port_f;
   logic       control_port, liberado, falha;
   logic [2:0] estado;

   typedef struct {
      string      nm;
      logic [2:0] est;
      logic       ctl;
      logic       lib;
      logic       fal;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   sequenciador_porta #(.DWELL_CICLOS(8), .TIMEOUT_CICLOS(12), .CW(4)) dut (
      .clock_in     (clock_in),
      .reset_n      (reset_n),
      .chegou       (chegou),
      .botao_abrir  (botao_abrir),
      .obstaculo    (obstaculo),
      .port_a       (port_a),
      .port_f       (port_f),
      .control_port (control_port),
      .liberado     (liberado),
      .falha        (falha),
      .estado       (estado)
   );

   always #5 clock_in = ~clock_in;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock_in);
         #1;
      end
   endtask

   task automatic expect_out(input string nm, input logic [2:0] est, input logic ctl,
                             input logic lib, input logic fal);
      exp_t e;
      e.nm  = nm;
      e.est = est;
      e.ctl = ctl;
      e.lib = lib;
      e.fal = fal;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every queued expectation against the live outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clock_in);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({estado, control_port, liberado, falha} !== {e.est, e.ctl, e.lib, e.fal}) begin
               errors++;
               $display("FAIL %s: got estado=%0d control_port=%b liberado=%b falha=%b, expected estado=%0d control_port=%b liberado=%b falha=%b",
                        e.nm, estado, control_port, liberado, falha, e.est, e.ctl, e.lib, e.fal);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; chegou = 1'b0; botao_abrir = 1'b0; obstaculo = 1'b0;
      port_a = 1'b0; port_f = 1'b1;
      #2;
      expect_out("reset", 3'd0, 1'b1, 1'b1, 1'b0);
      @(negedge clock_in);
      tick();
      reset_n = 1'b1;

      // Arrival: open, dwell 9 cycles, close, feedback closes
      chegou = 1'b1;
      tick();
      chegou = 1'b0; port_f = 1'b0;
      expect_out("open_cmd", 3'd1, 1'b0, 1'b0, 1'b0);
      tick(3);
      expect_out("abrindo_wait", 3'd1, 1'b0, 1'b0, 1'b0);
      port_a = 1'b1;
      tick();
      expect_out("aberta_enter", 3'd2, 1'b0, 1'b0, 1'b0);
      tick(8);
      expect_out("aberta_last", 3'd2, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("fechando", 3'd3, 1'b1, 1'b0, 1'b0);
      port_a = 1'b0;
      tick(2);
      port_f = 1'b1;
      tick();
      expect_out("fechada_back", 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
      port_f = 1'b0;
      expect_out("liberado_needs_port_f", 3'd0, 1'b1, 1'b0, 1'b0);
      tick();
      port_f = 1'b1;

      // Obstruction during dwell reloads the counter
      botao_abrir = 1'b1;
      tick();
      botao_abrir = 1'b0; port_f = 1'b0;
      tick();
      port_a = 1'b1;
      tick();
      tick(5);
      obstaculo = 1'b1;
      tick(5);
      obstaculo = 1'b0;
      expect_out("obst_hold", 3'd2, 1'b0, 1'b0, 1'b0);
      tick(8);
      expect_out("obst_still_open", 3'd2, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("obst_close", 3'd3, 1'b1, 1'b0, 1'b0);
      port_a = 1'b0;

      // Reopen beats simultaneous port_f in FECHANDO
      obstaculo = 1'b1; port_f = 1'b1;
      tick();
      obstaculo = 1'b0; port_f = 1'b0;
      expect_out("reopen_wins", 3'd1, 1'b0, 1'b0, 1'b0);
      chegou = 1'b1;
      tick();
      chegou = 1'b0;
      expect_out("chegou_ignored", 3'd1, 1'b0, 1'b0, 1'b0);

      // Opening timeout: 12 cycles in ABRINDO without port_a
      tick(10);
      expect_out("abrindo_pre_timeout", 3'd1, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("timeout_falha", 3'd4, 1'b0, 1'b0, 1'b1);
      chegou = 1'b1; botao_abrir = 1'b1; port_f = 1'b1;
      tick(2);
      chegou = 1'b0; botao_abrir = 1'b0;
      expect_out("falha_sticky", 3'd4, 1'b0, 1'b0, 1'b1);
      tick();
      reset_n = 1'b0;
      #1;
      expect_out("falha_reset", 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
      reset_n = 1'b1;

      // Asynchronous reset in the middle of FECHANDO
      chegou = 1'b1;
      tick();
      chegou = 1'b0; port_f = 1'b0; port_a = 1'b1;
      tick();
      tick(9);
      expect_out("fechando_pre_reset", 3'd3, 1'b1, 1'b0, 1'b0);
      port_a = 1'b0;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      expect_out("async_reset", 3'd0, 1'b1, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;

      // port_a and port_f together while opening
      chegou = 1'b1;
      tick();
      chegou = 1'b0; port_a = 1'b1; port_f = 1'b1;
      tick();
      expect_out("inconsistent", 3'd4, 1'b0, 1'b0, 1'b1);
      port_a = 1'b0; port_f = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;

      // Closing timeout: 12 cycles in FECHANDO without port_f
      chegou = 1'b1;
      tick();
      chegou = 1'b0; port_a = 1'b1;
      tick();
      tick(9);
      port_a = 1'b0;
      tick(11);
      expect_out("fechando_pre_timeout", 3'd3, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("close_timeout", 3'd4, 1'b0, 1'b0, 1'b1);

      repeat (4) @(negedge clock_in);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
